// File: rtl/aes_pkg.sv
// aes_pkg: AES S-box, round helper functions, Nk/Nr derivation and FSM state type
package aes_pkg;
  localparam int NB = 4;
  localparam int NR_OFFSET = 6;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} aes_state_t;
  function automatic int nk_of(input int key_bits);
    return key_bits / 32;
  endfunction
  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + NR_OFFSET;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < NB; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction
endpackage

// File: rtl/aes_enc_iter_round.sv
// aes_iter_round: combinational AES round, MixColumns skipped on the last round
module aes_iter_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] state_nxt
);
  logic [127:0] sb, sr, mc;
  always_comb begin
    sb = {sub_word(state[127:96]), sub_word(state[95:64]), sub_word(state[63:32]), sub_word(state[31:0])};
    sr = shift_rows(sb);
    mc = {mix_column(sr[127:96]), mix_column(sr[95:64]), mix_column(sr[63:32]), mix_column(sr[31:0])};
    state_nxt = (last ? sr : mc) ^ rk;
  end
endmodule

// File: rtl/aes_enc_iter.sv
// aes_enc_iter: iterative AES-128/192/256 encryptor, one round per clock; AES_BLK_CNT_EN adds blk_cnt output
module aes_enc_iter
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [KEY_BITS-1:0] key,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        data_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        data_out,
  output logic                key_ok
`ifdef AES_BLK_CNT_EN
  ,
  output logic [31:0]         blk_cnt
`endif
);
  localparam int NK = nk_of(KEY_BITS);
  localparam int NR = nr_of(KEY_BITS);
  localparam int NW = NB * (NR + 1);
  localparam logic [5:0] NK_W = 6'(NK);
  localparam logic [5:0] WI_LAST = 6'(NW - 1);
  localparam logic [2:0] KC_MAX = 3'(NK - 1);
  localparam logic [3:0] NR_R = 4'(NR);
  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_enc_iter: KEY_BITS must be 128, 192 or 256");
  end
  aes_state_t st;
  logic [31:0] w [NW];
  logic [5:0] wi;
  logic [2:0] kc;
  logic [7:0] rcon;
  logic [3:0] r;
  logic [127:0] s, s_nxt, rk;
  logic [31:0] w_prev, w_tmp;
  logic key_acc, blk_acc;
  assign in_ready = key_ready & key_ok & ~key_valid;
  assign key_acc = key_valid & key_ready;
  assign blk_acc = in_valid & in_ready;
  assign rk = {w[{r, 2'b00}], w[{r, 2'b01}], w[{r, 2'b10}], w[{r, 2'b11}]};
  always_comb begin
    w_prev = w[wi - 6'd1];
    w_tmp = kc == 3'd0 ? sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon, 24'h0}
          : (NK == 8 && kc == 3'd4) ? sub_word(w_prev) : w_prev;
  end
  aes_iter_round u_round (
    .state(s),
    .rk(rk),
    .last(r == NR_R),
    .state_nxt(s_nxt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      key_ready <= 1'b0;
      key_ok <= 1'b0;
      out_valid <= 1'b0;
      data_out <= '0;
      r <= '0;
      wi <= '0;
      kc <= '0;
      rcon <= 8'h01;
    end else begin
      case (st)
        IDLE: begin
          key_ready <= !(key_acc || blk_acc);
          if (key_acc) begin
            for (int j = 0; j < NK; j++) w[6'(j)] <= key[KEY_BITS-1-32*j -: 32];
            wi <= NK_W;
            kc <= '0;
            rcon <= 8'h01;
            key_ok <= 1'b0;
            st <= KEYEXP;
          end else if (blk_acc) begin
            s <= data_in ^ rk;
            r <= 4'd1;
            st <= ROUND;
          end
        end
        KEYEXP: begin
          w[wi] <= w[wi - NK_W] ^ w_tmp;
          wi <= wi + 6'd1;
          kc <= kc == KC_MAX ? 3'd0 : kc + 3'd1;
          if (kc == 3'd0) rcon <= xtime(rcon);
          if (wi == WI_LAST) begin
            key_ok <= 1'b1;
            key_ready <= 1'b1;
            st <= IDLE;
          end
        end
        ROUND: begin
          s <= s_nxt;
          r <= r + 4'd1;
          if (r == NR_R) begin
            data_out <= s_nxt;
            out_valid <= 1'b1;
            r <= '0;
            st <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          key_ready <= 1'b1;
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
`ifdef AES_BLK_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || key_acc) blk_cnt <= '0;
    else if (out_valid && out_ready) blk_cnt <= blk_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_aes_enc_iter.sv
// tb_aes_enc_iter: randomized AES-128/192/256 checks against a GF(2^8)-derived reference model
module tb_aes_enc_iter;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] kv, kr, iv, ir, ov, ordy, ko;
  logic [255:0] keyw [3];
  logic [127:0] din [3];
  logic [127:0] dout [3];
  logic [31:0] cnt [3];
  logic [7:0] sb_t [256];
  int npass = 0;
  int ntot = 0;
  logic [255:0] fk [3] = '{
    256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000,
    256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000,
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f};
  logic [127:0] fct [3] = '{
    128'h69c4e0d86a7b0430d8cdb78070b4c55a,
    128'hdda97ca4864cdfe06eaf70a0ec0d7191,
    128'h8ea2b7ca516745bfeafc49904b496089};
  localparam logic [127:0] FPT = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;

  aes_enc_iter #(.KEY_BITS(128)) dut0 (
    .clk(clk), .rst(rst), .key_valid(kv[0]), .key_ready(kr[0]), .key(keyw[0][255:128]),
    .in_valid(iv[0]), .in_ready(ir[0]), .data_in(din[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .data_out(dout[0]), .key_ok(ko[0])
`ifdef AES_BLK_CNT_EN
    , .blk_cnt(cnt[0])
`endif
  );
  aes_enc_iter #(.KEY_BITS(192)) dut1 (
    .clk(clk), .rst(rst), .key_valid(kv[1]), .key_ready(kr[1]), .key(keyw[1][255:64]),
    .in_valid(iv[1]), .in_ready(ir[1]), .data_in(din[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .data_out(dout[1]), .key_ok(ko[1])
`ifdef AES_BLK_CNT_EN
    , .blk_cnt(cnt[1])
`endif
  );
  aes_enc_iter #(.KEY_BITS(256)) dut2 (
    .clk(clk), .rst(rst), .key_valid(kv[2]), .key_ready(kr[2]), .key(keyw[2]),
    .in_valid(iv[2]), .in_ready(ir[2]), .data_in(din[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .data_out(dout[2]), .key_ok(ko[2])
`ifdef AES_BLK_CNT_EN
    , .blk_cnt(cnt[2])
`endif
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb_t[x[31:24]], sb_t[x[23:16]], sb_t[x[15:8]], sb_t[x[7:0]]};
  endfunction

  function automatic logic [127:0] model_enc(input logic [255:0] k, input int nk, input logic [127:0] pt);
    logic [31:0] wk [60];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [31:0] tmp;
    logic [7:0] rc;
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) wk[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = wk[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) tmp = subw(tmp);
      wk[i] = wk[i-nk] ^ tmp;
    end
    for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ wk[n/4][31-8*(n%4) -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int n = 0; n < 16; n++) t[n] = sb_t[s[n]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rd != nr)
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++)
            t[r] = gmul(s[4*c+r], 8'h02) ^ gmul(s[4*c+(r+1)%4], 8'h03) ^ s[4*c+(r+2)%4] ^ s[4*c+(r+3)%4];
          for (int r = 0; r < 4; r++) s[4*c+r] = t[r];
        end
      for (int n = 0; n < 16; n++) s[n] ^= wk[4*rd + n/4][31-8*(n%4) -: 8];
    end
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input int i, input logic [255:0] k);
    int n;
    n = 0;
    keyw[i] = k;
    kv[i] = 1'b1;
    while (!kr[i] && n < 200) begin
      tick();
      n++;
    end
    chk("key_ready_wait", 128'(n < 200), 128'(1));
    tick();
    kv[i] = 1'b0;
    chk("key_ok_drop", 128'(ko[i]), 128'(0));
    n = 0;
    while (!ko[i] && n < 200) begin
      tick();
      n++;
    end
    chk("keyexp_len", 128'(n), 128'(4*(11+2*i)-(4+2*i)));
  endtask

  task automatic send_block(input int i, input logic [127:0] pt, output logic [127:0] ct);
    int n;
    n = 0;
    din[i] = pt;
    iv[i] = 1'b1;
    while (!ir[i] && n < 200) begin
      tick();
      n++;
    end
    chk("in_ready_wait", 128'(n < 200), 128'(1));
    tick();
    iv[i] = 1'b0;
    n = 0;
    while (!ov[i] && n < 200) begin
      tick();
      n++;
    end
    chk("latency", 128'(n), 128'(10+2*i));
    ct = dout[i];
  endtask

  initial begin
    logic [127:0] ct, pt, exp;
    logic [255:0] k;
    logic [7:0] inv, b;
    int n;
    logic seen;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
    rst = 1'b1;
    kv = '0;
    iv = '0;
    ordy = '1;
    for (int i = 0; i < 3; i++) begin
      keyw[i] = '0;
      din[i] = '0;
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      chk("rst_key_ready", 128'(kr[i]), 128'(0));
      chk("rst_in_ready", 128'(ir[i]), 128'(0));
      chk("rst_out_valid", 128'(ov[i]), 128'(0));
      chk("rst_data_out", dout[i], 128'(0));
      chk("rst_key_ok", 128'(ko[i]), 128'(0));
    end
    rst = 1'b0;
    iv[0] = 1'b1;
    din[0] = rnd128();
    repeat (4) begin
      tick();
      chk("in_ready_no_key", 128'(ir[0]), 128'(0));
    end
    iv[0] = 1'b0;
    chk("no_out_no_key", 128'(ov[0]), 128'(0));
    for (int i = 0; i < 3; i++) begin
      load_key(i, fk[i]);
      send_block(i, FPT, ct);
      chk("fips_ct", ct, fct[i]);
      tick();
    end
    for (int i = 0; i < 3; i++)
      repeat (2) begin
        k = {rnd128(), rnd128()};
        load_key(i, k);
        repeat (3) begin
          pt = rnd128();
          send_block(i, pt, ct);
          chk("rand_ct", ct, model_enc(k, 4 + 2*i, pt));
          tick();
        end
      end
    k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    load_key(0, k);
    ordy[0] = 1'b0;
    send_block(0, 128'h3243f6a8885a308d313198a2e0370734, ct);
    chk("bp_ct", ct, 128'h3925841d02dc09fbdc118597196a0b32);
    iv[0] = 1'b1;
    din[0] = rnd128();
    repeat (20) begin
      tick();
      chk("bp_hold_data", dout[0], 128'h3925841d02dc09fbdc118597196a0b32);
      chk("bp_hold_valid", 128'(ov[0]), 128'(1));
      chk("bp_in_ready", 128'(ir[0]), 128'(0));
      chk("bp_key_ready", 128'(kr[0]), 128'(0));
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    tick();
    chk("bp_release", 128'(ov[0]), 128'(0));
    chk("reuse_key_ok", 128'(ko[0]), 128'(1));
    chk("reuse_in_ready", 128'(ir[0]), 128'(1));
    pt = rnd128();
    send_block(0, pt, ct);
    chk("reuse_ct", ct, model_enc(k, 4, pt));
    tick();
    k = {rnd128(), 128'h0};
    keyw[0] = k;
    kv[0] = 1'b1;
    iv[0] = 1'b1;
    din[0] = rnd128();
    #1;
    chk("arb_in_ready", 128'(ir[0]), 128'(0));
    chk("arb_key_ready", 128'(kr[0]), 128'(1));
    tick();
    kv[0] = 1'b0;
    iv[0] = 1'b0;
    chk("arb_key_taken", 128'(ko[0]), 128'(0));
    n = 0;
    seen = 1'b0;
    while (!ko[0] && n < 200) begin
      tick();
      n++;
      seen |= ov[0];
    end
    chk("arb_keyexp_len", 128'(n), 128'(40));
    chk("arb_no_block", 128'(seen), 128'(0));
    pt = rnd128();
    send_block(0, pt, ct);
    chk("arb_new_key_ct", ct, model_enc(k, 4, pt));
    tick();
    din[0] = rnd128();
    iv[0] = 1'b1;
    n = 0;
    while (!ir[0] && n < 200) begin
      tick();
      n++;
    end
    tick();
    iv[0] = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen |= ov[0];
    end
    chk("rst_mid_no_out", 128'(seen), 128'(0));
    chk("rst_mid_key_ok", 128'(ko[0]), 128'(0));
    iv[0] = 1'b1;
    #1;
    chk("rst_mid_in_ready", 128'(ir[0]), 128'(0));
    tick();
    iv[0] = 1'b0;
    k = {rnd128(), 128'h0};
    load_key(0, k);
    pt = rnd128();
    send_block(0, pt, ct);
    chk("rst_recover_ct", ct, model_enc(k, 4, pt));
    tick();
`ifdef AES_BLK_CNT_EN
    k = {rnd128(), 128'h0};
    load_key(0, k);
    chk("cnt_after_key", 128'(cnt[0]), 128'(0));
    repeat (3) begin
      pt = rnd128();
      send_block(0, pt, ct);
      chk("cnt_blk_ct", ct, model_enc(k, 4, pt));
      tick();
    end
    chk("cnt_three", 128'(cnt[0]), 128'(3));
    load_key(0, {rnd128(), 128'h0});
    chk("cnt_cleared", 128'(cnt[0]), 128'(0));
    force dut0.blk_cnt = 32'hffffffff;
    tick();
    release dut0.blk_cnt;
    tick();
    chk("cnt_preload", 128'(cnt[0]), 128'(32'hffffffff));
    send_block(0, rnd128(), ct);
    tick();
    chk("cnt_wrap", 128'(cnt[0]), 128'(0));
`endif
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
